reg_bank_v: RTL and testbench

- Parametrised bank of DEPTH write-enabled registers, each WIDTH bits.
- Each register has byte-strobe writes, a shadow/active pair with an atomic commit, a write lock, and a registered read port.
- Serves as the generic configuration-register store between a bus-side write/read interface and datapath logic.
- Datapath logic consumes all active values in parallel.

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_cell_v.sv | 87 ++++++++
 rtl/reg_bank_v.sv | 119 +++++++++++
 tb/tb_reg_bank_v.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared helpers for the configuration register bank.
//   - addr_w_f    : address width for a given register count (at least 1 bit)
//   - merge_byte  : one byte of a strobed write merge (old, new, strobe) -> merged
//   - R_SRC_*     : read source select encodings
package reg_bank_pkg;

   localparam logic R_SRC_ACTIVE = 1'b0;
   localparam logic R_SRC_SHADOW = 1'b1;

   function automatic int unsigned addr_w_f(int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   function automatic logic [7:0] merge_byte(logic [7:0] old_b, logic [7:0] new_b, logic strb);
      return strb ? new_b : old_b;
   endfunction

endpackage

// File: rtl/reg_cell_v.sv
// reg_cell_v: one configuration register as a shadow/active pair.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   wr_en_i          accepted write to this register (already decoded/qualified)
//   wr_strb_i        byte enables for the write
//   wr_data_i        write data
//   commit_i         copy shadow to active (ignored when SHADOWED=0)
//   shadow_o         shadow value (equals active when SHADOWED=0)
//   active_o         active value
module reg_cell_v
   import reg_bank_pkg::*;
#(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SHADOWED  = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               wr_en_i,
   input  logic [WIDTH/8-1:0] wr_strb_i,
   input  logic [WIDTH-1:0]   wr_data_i,
   input  logic               commit_i,
   output logic [WIDTH-1:0]   shadow_o,
   output logic [WIDTH-1:0]   active_o
);

   localparam int unsigned NBytes = WIDTH / 8;

   logic [WIDTH-1:0] wr_target;
   logic [WIDTH-1:0] merged;

   always_comb begin
      merged = '0;
      for (int unsigned k = 0; k < NBytes; k++) begin
         merged[k*8 +: 8] = merge_byte(wr_target[k*8 +: 8], wr_data_i[k*8 +: 8], wr_strb_i[k]);
      end
   end

   if (SHADOWED) begin : g_shadow
      logic [WIDTH-1:0] shadow_q, shadow_d;
      logic [WIDTH-1:0] active_q, active_d;

      assign wr_target = shadow_q;

      // Commit takes the pre-edge shadow, so a same-cycle write needs a later commit.
      always_comb begin
         shadow_d = wr_en_i  ? merged   : shadow_q;
         active_d = commit_i ? shadow_q : active_q;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            shadow_q <= RESET_VAL;
            active_q <= RESET_VAL;
         end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
         end
      end

      assign shadow_o = shadow_q;
      assign active_o = active_q;
   end else begin : g_direct
      logic [WIDTH-1:0] active_q, active_d;
      logic             unused_commit;

      assign unused_commit = commit_i;
      assign wr_target     = active_q;

      always_comb begin
         active_d = wr_en_i ? merged : active_q;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            active_q <= RESET_VAL;
         end else begin
            active_q <= active_d;
         end
      end

      // No shadow storage: shadow reads see the active value.
      assign shadow_o = active_q;
      assign active_o = active_q;
   end

endmodule

// File: rtl/reg_bank_v.sv
// reg_bank_v: bank of DEPTH configuration registers, WIDTH bits each, with byte-strobe
// writes, shadow/active pairs with atomic commit, write lock and a registered read port.
// Ports:
//   clock, reset_n           clock, asynchronous active-low reset
//   w_en_in/w_addr_in/w_strb_in/w_data_in   write request
//   commit_in                copy every shadow to active
//   lock_in                  blocks writes while high
//   r_en_in/r_addr_in/r_src_in              read request (src 0 = active, 1 = shadow)
//   r_data_out, r_valid_out  registered read response, one-cycle latency
//   err_out, err_clr_in      sticky error flag and its clear
//   active_flat_out          all active registers, register i at [i*WIDTH +: WIDTH]
module reg_bank_v
   import reg_bank_pkg::*;
#(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      DEPTH     = 8,
   parameter int unsigned      ADDR_W    = addr_w_f(DEPTH),
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SHADOWED  = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   w_en_in,
   input  logic [ADDR_W-1:0]      w_addr_in,
   input  logic [WIDTH/8-1:0]     w_strb_in,
   input  logic [WIDTH-1:0]       w_data_in,
   input  logic                   commit_in,
   input  logic                   lock_in,
   input  logic                   r_en_in,
   input  logic [ADDR_W-1:0]      r_addr_in,
   input  logic                   r_src_in,
   output logic [WIDTH-1:0]       r_data_out,
   output logic                   r_valid_out,
   output logic                   err_out,
   input  logic                   err_clr_in,
   output logic [DEPTH*WIDTH-1:0] active_flat_out
);

   logic [WIDTH-1:0] shadow_arr [DEPTH];
   logic [WIDTH-1:0] active_arr [DEPTH];

   logic             w_in_range;
   logic             r_in_range;
   logic             write_ok;
   logic             err_set;
   logic [WIDTH-1:0] rd_sel;

   logic [WIDTH-1:0] r_data_q, r_data_d;
   logic             r_valid_q, r_valid_d;
   logic             err_q, err_d;

   assign w_in_range = 32'(w_addr_in) < DEPTH;
   assign r_in_range = 32'(r_addr_in) < DEPTH;
   assign write_ok   = w_en_in && !lock_in && w_in_range && (|w_strb_in);

   // Blocked and out-of-range writes flag an error even with a zero strobe.
   assign err_set = (w_en_in && lock_in) || (w_en_in && !w_in_range) || (r_en_in && !r_in_range);

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      logic we;
      assign we = write_ok && (w_addr_in == ADDR_W'(i));

      reg_cell_v #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL),
         .SHADOWED  (SHADOWED)
      ) u_cell (
         .clk_i     (clock),
         .rst_ni    (reset_n),
         .wr_en_i   (we),
         .wr_strb_i (w_strb_in),
         .wr_data_i (w_data_in),
         .commit_i  (commit_in),
         .shadow_o  (shadow_arr[i]),
         .active_o  (active_arr[i])
      );

      assign active_flat_out[i*WIDTH +: WIDTH] = active_arr[i];
   end

   // Out-of-range indices match no entry and leave rd_sel at zero.
   always_comb begin
      rd_sel = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (32'(r_addr_in) == i) begin
            rd_sel = (r_src_in == R_SRC_SHADOW) ? shadow_arr[i] : active_arr[i];
         end
      end
   end

   always_comb begin
      r_valid_d = r_en_in;
      r_data_d  = r_en_in ? rd_sel : r_data_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr_in) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         r_data_q  <= r_data_d;
         r_valid_q <= r_valid_d;
         err_q     <= err_d;
      end
   end

   assign r_data_out  = r_data_q;
   assign r_valid_out = r_valid_q;
   assign err_out     = err_q;

endmodule

// File: tb/tb_reg_bank_v.sv
module tb_reg_bank_v;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n = 1'b1;

   // Main DUT: WIDTH=16, DEPTH=8, shadowed.
   logic         w_en, commit, lock, r_en, r_src, err_clr;
   logic [2:0]   w_addr, r_addr;
   logic [1:0]   w_strb;
   logic [15:0]  w_data;
   logic [15:0]  r_data;
   logic         r_valid, err;
   logic [127:0] flat;

   // Second DUT: DEPTH=5, not shadowed.
   logic         q_w_en, q_r_en, q_r_src, q_err_clr;
   logic [2:0]   q_w_addr, q_r_addr;
   logic [1:0]   q_w_strb;
   logic [15:0]  q_w_data;
   logic [15:0]  q_r_data;
   logic         q_r_valid, q_err;
   logic [79:0]  q_flat;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state for the main DUT.
   logic [15:0] m_sh [8];
   logic [15:0] m_ac [8];
   logic [15:0] m_rdata;
   logic        m_rvalid;
   logic        m_err;

   reg_bank_v #(
      .WIDTH     (16),
      .DEPTH     (8),
      .RESET_VAL (16'h0000),
      .SHADOWED  (1'b1)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .w_en_in         (w_en),
      .w_addr_in       (w_addr),
      .w_strb_in       (w_strb),
      .w_data_in       (w_data),
      .commit_in       (commit),
      .lock_in         (lock),
      .r_en_in         (r_en),
      .r_addr_in       (r_addr),
      .r_src_in        (r_src),
      .r_data_out      (r_data),
      .r_valid_out     (r_valid),
      .err_out         (err),
      .err_clr_in      (err_clr),
      .active_flat_out (flat)
   );

   reg_bank_v #(
      .WIDTH     (16),
      .DEPTH     (5),
      .RESET_VAL (16'h0000),
      .SHADOWED  (1'b0)
   ) dut5 (
      .clock           (clock),
      .reset_n         (reset_n),
      .w_en_in         (q_w_en),
      .w_addr_in       (q_w_addr),
      .w_strb_in       (q_w_strb),
      .w_data_in       (q_w_data),
      .commit_in       (1'b0),
      .lock_in         (1'b0),
      .r_en_in         (q_r_en),
      .r_addr_in       (q_r_addr),
      .r_src_in        (q_r_src),
      .r_data_out      (q_r_data),
      .r_valid_out     (q_r_valid),
      .err_out         (q_err),
      .err_clr_in      (q_err_clr),
      .active_flat_out (q_flat)
   );

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_sh[i] = 16'h0000;
         m_ac[i] = 16'h0000;
      end
      m_rdata  = 16'h0000;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
   endtask

   // One clock edge of the bank, from the behavioural rules.
   task automatic model_edge();
      logic [15:0] old_sh [8];
      for (int i = 0; i < 8; i++) old_sh[i] = m_sh[i];
      if (r_en) m_rdata = r_src ? m_sh[r_addr] : m_ac[r_addr];
      m_rvalid = r_en;
      if (w_en && lock) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (w_en && !lock) begin
         for (int k = 0; k < 2; k++) begin
            if (w_strb[k]) m_sh[w_addr][k*8 +: 8] = w_data[k*8 +: 8];
         end
      end
      if (commit) begin
         for (int i = 0; i < 8; i++) m_ac[i] = old_sh[i];
      end
   endtask

   function automatic logic [127:0] exp_flat();
      logic [127:0] f;
      for (int i = 0; i < 8; i++) f[i*16 +: 16] = m_ac[i];
      return f;
   endfunction

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic step();
      @(posedge clock);
      if (reset_n) model_edge();
      @(negedge clock);
   endtask

   task automatic idle();
      w_en = 0; w_addr = 0; w_strb = 0; w_data = 0; commit = 0; lock = 0;
      r_en = 0; r_addr = 0; r_src = 0; err_clr = 0;
      q_w_en = 0; q_w_addr = 0; q_w_strb = 0; q_w_data = 0;
      q_r_en = 0; q_r_addr = 0; q_r_src = 0; q_err_clr = 0;
   endtask

   task automatic test_reset();
      idle();
      reset_n = 1'b0;
      #12;
      n_cmp++; if (r_data !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", r_data); end
      n_cmp++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", r_valid); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if (flat !== 128'h0) begin n_fail++; $display("FAIL reset_flat: got %h want 0", flat); end
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 8; a++) begin
            r_en = 1; r_src = 1'(s); r_addr = 3'(a);
            step();
            n_cmp++; if (r_valid !== 1'b1 || r_data !== 16'h0000) begin
               n_fail++; $display("FAIL reset_read src%0d addr%0d: got v=%b d=%h want v=1 d=0000", s, a, r_valid, r_data);
            end
         end
      end
      r_en = 0;
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_read_err: got %b want 0", err); end
   endtask

   task automatic test_strobe();
      w_en = 1; w_addr = 3; w_data = 16'hABCD; w_strb = 2'b01;
      step();
      w_en = 0; r_en = 1; r_src = 1; r_addr = 3;
      step();
      r_en = 0;
      n_cmp++; if (r_data !== 16'h00CD) begin n_fail++; $display("FAIL strobe_shadow: got %h want 00cd", r_data); end
      n_cmp++; if (flat[48 +: 16] !== 16'h0000) begin n_fail++; $display("FAIL strobe_active_precommit: got %h want 0000", flat[48 +: 16]); end
      commit = 1;
      step();
      commit = 0;
      n_cmp++; if (flat[48 +: 16] !== 16'h00CD) begin n_fail++; $display("FAIL strobe_commit: got %h want 00cd", flat[48 +: 16]); end
   endtask

   task automatic test_collide();
      w_en = 1; w_addr = 2; w_data = 16'h5555; w_strb = 2'b11;
      step();
      w_data = 16'h1234; commit = 1;
      step();
      w_en = 0; commit = 0;
      n_cmp++; if (flat[32 +: 16] !== 16'h5555) begin n_fail++; $display("FAIL collide_active: got %h want 5555", flat[32 +: 16]); end
      r_en = 1; r_src = 1; r_addr = 2;
      step();
      r_en = 0;
      n_cmp++; if (r_data !== 16'h1234) begin n_fail++; $display("FAIL collide_shadow: got %h want 1234", r_data); end
      commit = 1;
      step();
      commit = 0;
      n_cmp++; if (flat[32 +: 16] !== 16'h1234) begin n_fail++; $display("FAIL collide_second_commit: got %h want 1234", flat[32 +: 16]); end
   endtask

   task automatic test_lock();
      lock = 1; w_en = 1; w_addr = 1; w_data = 16'hFFFF; w_strb = 2'b11;
      step();
      w_en = 0;
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL lock_err: got %b want 1", err); end
      r_en = 1; r_src = 1; r_addr = 1;
      step();
      r_en = 0;
      n_cmp++; if (r_data !== 16'h0000) begin n_fail++; $display("FAIL lock_shadow_unchanged: got %h want 0000", r_data); end
      err_clr = 1;
      step();
      err_clr = 0;
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL lock_err_clr: got %b want 0", err); end
      lock = 0; w_en = 1; w_data = 16'h0F0F;
      step();
      w_en = 0; lock = 1; commit = 1;
      step();
      commit = 0; lock = 0;
      n_cmp++; if (flat[16 +: 16] !== 16'h0F0F) begin n_fail++; $display("FAIL lock_commit: got %h want 0f0f", flat[16 +: 16]); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL lock_commit_err: got %b want 0", err); end
   endtask

   task automatic test_err_priority();
      lock = 1; w_en = 1; w_addr = 4; w_data = 16'h1111; w_strb = 2'b11;
      step();
      err_clr = 1;
      step();
      w_en = 0; lock = 0;
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b want 1", err); end
      step();
      err_clr = 0;
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
      // Zero strobe: no change and no error.
      w_en = 1; w_addr = 2; w_data = 16'hDEAD; w_strb = 2'b00;
      step();
      w_en = 0; r_en = 1; r_src = 1; r_addr = 2;
      step();
      r_en = 0;
      n_cmp++; if (r_data !== 16'h1234 || err !== 1'b0) begin
         n_fail++; $display("FAIL zero_strobe: got d=%h e=%b want d=1234 e=0", r_data, err);
      end
      step();
      n_cmp++; if (r_valid !== 1'b0 || r_data !== 16'h1234) begin
         n_fail++; $display("FAIL read_hold: got v=%b d=%h want v=0 d=1234", r_valid, r_data);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         w_en    = 1'($urandom_range(0, 1));
         w_addr  = 3'($urandom);
         w_strb  = 2'($urandom);
         w_data  = 16'($urandom);
         commit  = ($urandom_range(0, 5) == 0);
         lock    = ($urandom_range(0, 9) == 0);
         r_en    = 1'($urandom_range(0, 1));
         r_addr  = 3'($urandom);
         r_src   = 1'($urandom_range(0, 1));
         err_clr = ($urandom_range(0, 6) == 0);
         step();
         n_cmp++; if (r_valid !== m_rvalid || r_data !== m_rdata) begin
            n_fail++; $display("FAIL rand_read @%0d: got v=%b d=%h want v=%b d=%h", n, r_valid, r_data, m_rvalid, m_rdata);
         end
         n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err @%0d: got %b want %b", n, err, m_err); end
         n_cmp++; if (flat !== exp_flat()) begin n_fail++; $display("FAIL rand_flat @%0d: got %h want %h", n, flat, exp_flat()); end
      end
      idle();
      err_clr = 1;
      step();
      err_clr = 0;
   endtask

   task automatic test_oor();
      q_w_en = 1; q_w_addr = 4; q_w_data = 16'hBEEF; q_w_strb = 2'b11;
      step();
      q_w_en = 0;
      n_cmp++; if (q_flat !== {16'hBEEF, 64'h0}) begin n_fail++; $display("FAIL d5_direct_write: got %h want beef + 0s", q_flat); end
      q_r_en = 1; q_r_addr = 4; q_r_src = 1;
      step();
      q_r_en = 0;
      n_cmp++; if (q_r_data !== 16'hBEEF) begin n_fail++; $display("FAIL d5_src_ignored: got %h want beef", q_r_data); end
      q_w_en = 1; q_w_addr = 6; q_w_data = 16'h1111;
      step();
      q_w_en = 0;
      n_cmp++; if (q_err !== 1'b1 || q_flat !== {16'hBEEF, 64'h0}) begin
         n_fail++; $display("FAIL d5_oor_write: got e=%b flat=%h want e=1 unchanged", q_err, q_flat);
      end
      q_err_clr = 1;
      step();
      q_err_clr = 0;
      n_cmp++; if (q_err !== 1'b0) begin n_fail++; $display("FAIL d5_err_clr: got %b want 0", q_err); end
      q_r_en = 1; q_r_addr = 7; q_r_src = 0;
      step();
      q_r_en = 0;
      n_cmp++; if (q_r_data !== 16'h0 || q_r_valid !== 1'b1 || q_err !== 1'b1) begin
         n_fail++; $display("FAIL d5_oor_read: got d=%h v=%b e=%b want d=0000 v=1 e=1", q_r_data, q_r_valid, q_err);
      end
   endtask

   task automatic test_async_reset();
      for (int n = 0; n < 6; n++) begin
         w_en = 1; w_addr = 3'($urandom); w_data = 16'($urandom) | 16'h0101; w_strb = 2'b11;
         lock = (n == 0); commit = 1; r_en = 1; r_src = 1'($urandom_range(0, 1)); r_addr = 3'($urandom);
         step();
      end
      // Reset lands between edges, mid-burst.
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (r_valid !== 1'b0 || r_data !== 16'h0 || err !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_outs: got v=%b d=%h e=%b want 0/0000/0", r_valid, r_data, err);
      end
      n_cmp++; if (flat !== 128'h0) begin n_fail++; $display("FAIL async_reset_flat: got %h want 0", flat); end
      idle();
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      w_en = 1; w_addr = 5; w_data = 16'h77AA; w_strb = 2'b11;
      step();
      w_en = 0; r_en = 1; r_src = 1; r_addr = 5;
      step();
      r_en = 0;
      n_cmp++; if (r_valid !== 1'b1 || r_data !== 16'h77AA) begin
         n_fail++; $display("FAIL post_reset_read: got v=%b d=%h want v=1 d=77aa", r_valid, r_data);
      end
      n_cmp++; if (flat !== 128'h0 || err !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_state: got flat=%h e=%b want 0/0", flat, err);
      end
   endtask

   initial begin
      idle();
      model_reset();
      test_reset();
      test_strobe();
      test_collide();
      test_lock();
      test_err_priority();
      test_random();
      test_oor();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
